// File: rtl/watch_pkg.sv
// Shared watch definitions: key conditioner state encoding and the clock-derived
// default timings, so every key instance agrees on them.
package watch_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HOLD         = 3'd2,
        REPEAT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } key_state_t;

    localparam int unsigned CLK_HZ              = 50_000_000;
    localparam int unsigned KEY_DEBOUNCE_CYCLES = CLK_HZ / 50;  // 20 ms
    localparam int unsigned KEY_REPEAT_DELAY    = CLK_HZ / 2;   // 0.5 s
    localparam int unsigned KEY_REPEAT_PERIOD   = CLK_HZ / 10;  // 0.1 s
    localparam int          KEY_CNT_W           = 25;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser for asynchronous inputs; RESET_VAL sets the level
// both flops take on reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic ff1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ff1 <= RESET_VAL;
            q   <= RESET_VAL;
        end else begin
            ff1 <= d;
            q   <= ff1;
        end
    end

endmodule

// File: rtl/key_pulse_repeat.sv
// Turns one raw active-low push button into debounced one-clock command pulses,
// with optional auto-repeat while the key stays held.
module key_pulse_repeat
    import watch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = KEY_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = KEY_REPEAT_PERIOD,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int          CNT_W           = KEY_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic i_key,
    output logic o_pulse,
    output logic o_held
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             key_s;
    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pulse_nxt, held_nxt;

    // Synchroniser resets to the released level so reset never looks like a press.
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (i_key),
        .q     (key_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            o_pulse <= 1'b0;
            o_held  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            o_pulse <= pulse_nxt;
            o_held  <= held_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!key_s) state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                // A release on the terminal cycle is a glitch, so it wins over the pulse.
                if (key_s) begin
                    state_nxt = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_nxt = HOLD;
                    pulse_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (REPEAT_EN != 0) begin
                    if (cnt == RD_LAST) begin
                        state_nxt = REPEAT;
                        pulse_nxt = 1'b1;
                    end
                end else if (cnt == CNT_MAX) begin
                    cnt_nxt = cnt;
                end
                if (key_s) state_nxt = RELEASE_WAIT;
            end
            REPEAT: begin
                if (cnt == RP_LAST) begin
                    pulse_nxt = 1'b1;
                    cnt_nxt   = '0;
                end
                if (key_s) state_nxt = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed restarts the repeat delay without a new pulse.
                if (!key_s) begin
                    state_nxt = HOLD;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (state_nxt != state) cnt_nxt = '0;
        held_nxt = (state_nxt == HOLD) || (state_nxt == REPEAT) || (state_nxt == RELEASE_WAIT);
    end

endmodule
